fx_tx_encoder: RTL and testbench
================================

FX_TX_ENCODER -- requirements
Module: fx_tx_encoder

Interface
REQ-001 SHALL have port i_clk, input, 1, 125 MHz bit clock; all logic on its rising edge.
REQ-002 SHALL have port i_res_n, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port i_tx_en, input, 1, frame enable from MAC side (MII TX_EN semantics).
REQ-004 SHALL have port i_tx_er, input, 1, transmit error; forces /H/ in data symbols.
REQ-005 SHALL have port i_txd, input, 4, data nibble.
REQ-006 SHALL have port o_nib_ack, output, 1, one-cycle strobe; i_txd/i_tx_er sampled this cycle.
REQ-007 SHALL have port o_sym_start, output, 1, one-cycle strobe at each symbol boundary (25 MHz rate).
REQ-008 SHALL have port o_txdata, output, 1, NRZI-encoded 125 Mbps serial line data, registered.

Function
REQ-009 SHALL run a 3-bit bit counter 0..4, wrapping 4->0; boundary cycle = counter==4; o_sym_start high exactly in boundary cycles.
REQ-010 SHALL hold a 5-bit shift register, MSB transmitted first, shifting left once per non-boundary cycle; loaded with next symbol at end of boundary cycle.
REQ-011 SHALL implement states IDLE, SSD_J, SSD_K, DATA, ESD_T, ESD_R; next symbol and state chosen only in boundary cycles.
REQ-012 IDLE: emit /I/=11111; if i_tx_en=1 at boundary, next symbol /J/=11000, state SSD_J.
REQ-013 SSD_J: next /K/=10001 unconditionally, state SSD_K.
REQ-014 SSD_K/DATA: if i_tx_en=1, next symbol = 4B/5B code of i_txd (or /H/=00100 if i_tx_er=1), state DATA, o_nib_ack=1 that cycle; if i_tx_en=0, next /T/=01101, state ESD_T, o_nib_ack=0.
REQ-015 ESD_T: next /R/=00111, state ESD_R; ESD_R: next /I/, state IDLE regardless of i_tx_en (minimum one /I/ between frames).
REQ-016 i_tx_en/i_txd/i_tx_er SHALL be ignored outside boundary cycles; i_tx_en drop during SSD_J still completes J,K then T,R with no data.
REQ-017 4B/5B table SHALL be the standard 100BASE-X code (0=11110,1=01001,2=10100,3=10101,4=01010,5=01011,6=01110,7=01111,8=10010,9=10011,A=10110,B=10111,C=11010,D=11011,E=11100,F=11101).
REQ-018 NRZI: each cycle o_txdata <= o_txdata XOR shift[4]; a 1 toggles the line, a 0 holds.
REQ-019 Latency: first bit of a symbol loaded at a boundary affects o_txdata at the second rising edge after that boundary cycle.
REQ-020 o_nib_ack SHALL never be high outside a boundary cycle; at most one per symbol.

Reset
REQ-021 On i_res_n=0 (asynchronous): state IDLE, bit counter 0, shift=11111, o_txdata=0, o_nib_ack=0, o_sym_start=0.
REQ-022 Reset mid-frame SHALL abort immediately without T/R; after release transmission resumes with /I/.

Structure
REQ-023 Package fx_pcs_pkg SHALL hold 5-bit symbol constants (I,J,K,T,R,H), state enumeration, and the 4B/5B table.
REQ-024 Sub-module fx_4b5b_enc (combinational nibble+err -> 5-bit code) SHALL be instantiated once; remainder in fx_tx_encoder.

Verification
REQ-025 Reset release, i_tx_en=0 -> o_txdata toggles every cycle (0,1,0,1...), o_sym_start every 5th cycle.
REQ-026 Frame nibbles 0x5,0xA then i_tx_en=0 -> NRZI-decoded stream 11111 11000 10001 01011 10110 01101 00111 11111; exactly two o_nib_ack pulses.
REQ-027 i_tx_er=1 with i_txd=0x3 in DATA -> symbol 00100 sent, o_nib_ack=1.
REQ-028 i_tx_en 1 for only the J boundary -> decoded J,K,T,R,I, zero o_nib_ack.
REQ-029 i_tx_en re-asserted at the ESD_R-entry boundary -> at least one 11111 before next 11000.
REQ-030 i_res_n pulsed low mid-DATA -> o_txdata=0 asynchronously, no T/R, idle pattern follows release.

Source files
------------

// File: rtl/fx_pcs_pkg.sv
// rtl/fx_pcs_pkg.sv - 100BASE-X PCS transmit constants, FSM states and 4B/5B table
// Contents:
//   SYM_I/J/K/T/R/H : 5-bit control code-groups, MSB transmitted first
//   BIT_LAST        : bit counter value marking the symbol boundary cycle
//   fx_tx_state_e   : transmit FSM state enumeration
//   ENC_TABLE       : 4B/5B data code-groups indexed by nibble value
package fx_pcs_pkg;

    localparam logic [4:0] SYM_I = 5'b11111;
    localparam logic [4:0] SYM_J = 5'b11000;
    localparam logic [4:0] SYM_K = 5'b10001;
    localparam logic [4:0] SYM_T = 5'b01101;
    localparam logic [4:0] SYM_R = 5'b00111;
    localparam logic [4:0] SYM_H = 5'b00100;

    localparam logic [2:0] BIT_LAST = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SSD_J = 3'd1,
        ST_SSD_K = 3'd2,
        ST_DATA  = 3'd3,
        ST_ESD_T = 3'd4,
        ST_ESD_R = 3'd5
    } fx_tx_state_e;

    // Packed so that ENC_TABLE[nibble] selects the code-group; listed F down to 0.
    localparam logic [15:0][4:0] ENC_TABLE = {
        5'b11101, 5'b11100, 5'b11011, 5'b11010,
        5'b10111, 5'b10110, 5'b10011, 5'b10010,
        5'b01111, 5'b01110, 5'b01011, 5'b01010,
        5'b10101, 5'b10100, 5'b01001, 5'b11110
    };

endpackage

// File: rtl/fx_4b5b_enc.sv
// rtl/fx_4b5b_enc.sv - combinational 4B/5B data encoder with error substitution
// Ports:
//   nib  : data nibble from the MAC
//   err  : transmit error; substitutes /H/ for the data code-group
//   code : 5-bit code-group, MSB transmitted first
module fx_4b5b_enc
    import fx_pcs_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       err,
    output logic [4:0] code
);

    assign code = err ? SYM_H : ENC_TABLE[nib];

endmodule

// File: rtl/fx_tx_encoder.sv
// rtl/fx_tx_encoder.sv - 100BASE-X PCS transmit: framing FSM, 4B/5B, serializer, NRZI
// Ports:
//   i_clk       : 125 MHz bit clock, rising edge
//   i_res_n     : asynchronous active-low reset
//   i_tx_en     : MII TX_EN, sampled only in symbol boundary cycles
//   i_tx_er     : MII TX_ER, forces /H/ in place of a data code-group
//   i_txd       : MII TXD nibble
//   o_nib_ack   : strobe, i_txd/i_tx_er consumed this cycle
//   o_sym_start : strobe in the last bit cycle of every symbol (25 MHz)
//   o_txdata    : registered NRZI serial line data
module fx_tx_encoder
    import fx_pcs_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_res_n,
    input  logic       i_tx_en,
    input  logic       i_tx_er,
    input  logic [3:0] i_txd,
    output logic       o_nib_ack,
    output logic       o_sym_start,
    output logic       o_txdata
);

    fx_tx_state_e state, state_next;
    logic [2:0]   bit_cnt;
    logic [4:0]   shift;
    logic [4:0]   next_sym;
    logic [4:0]   data_code;
    logic         boundary;

    assign boundary = (bit_cnt == BIT_LAST);

    fx_4b5b_enc u_enc (
        .nib  (i_txd),
        .err  (i_tx_er),
        .code (data_code)
    );

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Decisions are taken only in boundary cycles; the inputs are don't-care elsewhere.
    always_comb begin
        state_next = state;
        if (boundary) begin
            case (state)
                ST_IDLE:           state_next = i_tx_en ? ST_SSD_J : ST_IDLE;
                ST_SSD_J:          state_next = ST_SSD_K;
                ST_SSD_K, ST_DATA: state_next = i_tx_en ? ST_DATA : ST_ESD_T;
                ST_ESD_T:          state_next = ST_ESD_R;
                ST_ESD_R:          state_next = ST_IDLE;
                default:           state_next = ST_IDLE;
            endcase
        end
    end

    // next_sym is only consumed in boundary cycles; nib_ack is qualified explicitly.
    always_comb begin
        o_sym_start = boundary;
        o_nib_ack   = 1'b0;
        next_sym    = SYM_I;
        case (state)
            ST_IDLE:  next_sym = i_tx_en ? SYM_J : SYM_I;
            ST_SSD_J: next_sym = SYM_K;
            ST_SSD_K, ST_DATA: begin
                if (i_tx_en) begin
                    next_sym  = data_code;
                    o_nib_ack = boundary;
                end else begin
                    next_sym  = SYM_T;
                end
            end
            ST_ESD_T: next_sym = SYM_R;
            ST_ESD_R: next_sym = SYM_I;
            default:  next_sym = SYM_I;
        endcase
    end

    // The shift register is reloaded instead of shifted in the boundary cycle, so
    // shift[4] walks through bits 0..4 while bit_cnt runs 0..4.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            bit_cnt  <= 3'd0;
            shift    <= SYM_I;
            o_txdata <= 1'b0;
        end else begin
            o_txdata <= o_txdata ^ shift[4];
            if (boundary) begin
                bit_cnt <= 3'd0;
                shift   <= next_sym;
            end else begin
                bit_cnt <= bit_cnt + 3'd1;
                shift   <= {shift[3:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_fx_tx_encoder.sv
// tb/tb_fx_tx_encoder.sv - directed self-checking bench for fx_tx_encoder
module tb_fx_tx_encoder;

    logic       i_clk = 1'b0;
    logic       i_res_n = 1'b0;
    logic       i_tx_en = 1'b0;
    logic       i_tx_er = 1'b0;
    logic [3:0] i_txd = 4'h0;
    logic       o_nib_ack;
    logic       o_sym_start;
    logic       o_txdata;

    int total = 0;
    int bad   = 0;

    fx_tx_encoder dut (
        .i_clk       (i_clk),
        .i_res_n     (i_res_n),
        .i_tx_en     (i_tx_en),
        .i_tx_er     (i_tx_er),
        .i_txd       (i_txd),
        .o_nib_ack   (o_nib_ack),
        .o_sym_start (o_sym_start),
        .o_txdata    (o_txdata)
    );

    always #4 i_clk = ~i_clk;

    // NRZI decoder and symbol framer. The bit observed in the cycle after a
    // o_sym_start cycle is the last bit of the symbol sent in that boundary cycle.
    logic [4:0] sym_q [$];
    logic [4:0] acc = 5'd0;
    logic       prev_tx = 1'b0;
    logic       prev_ss = 1'b0;
    int         stray_ack = 0;

    always @(negedge i_clk) begin
        acc = {acc[3:0], o_txdata ^ prev_tx};
        prev_tx = o_txdata;
        if (prev_ss) sym_q.push_back(acc);
        prev_ss = o_sym_start;
        if (o_nib_ack && !o_sym_start) stray_ack++;
    end

    // Waits for a boundary cycle, applies inputs, captures o_nib_ack, then puts
    // inverted noise on the inputs until the next boundary.
    task automatic drive_bnd(input logic en, input logic er, input logic [3:0] nib,
                             input bit clr, output logic ack);
        int n = 0;
        @(negedge i_clk);
        while (o_sym_start !== 1'b1 && n < 10) begin
            @(negedge i_clk);
            n++;
        end
        total++;
        if (o_sym_start !== 1'b1) begin
            bad++;
            $display("FAIL sym_start_wait: got=%b want=1 within 10 cycles", o_sym_start);
        end
        if (clr) sym_q.delete();
        i_tx_en = en;
        i_tx_er = er;
        i_txd   = nib;
        #1 ack = o_nib_ack;
        @(posedge i_clk);
        #1;
        i_tx_en = ~en;
        i_tx_er = ~er;
        i_txd   = ~nib;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge i_clk);
        #1;
        total++; if (o_txdata !== 1'b0)    begin bad++; $display("FAIL rst_txdata: got=%b want=0", o_txdata); end
        total++; if (o_sym_start !== 1'b0) begin bad++; $display("FAIL rst_sym_start: got=%b want=0", o_sym_start); end
        total++; if (o_nib_ack !== 1'b0)   begin bad++; $display("FAIL rst_nib_ack: got=%b want=0", o_nib_ack); end
        i_res_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge i_clk);
            total++;
            if (o_txdata !== 1'(k % 2)) begin
                bad++; $display("FAIL idle_toggle[%0d]: got=%b want=%b", k, o_txdata, 1'(k % 2));
            end
            total++;
            if (o_sym_start !== (k % 5 == 4)) begin
                bad++; $display("FAIL idle_sym_start[%0d]: got=%b want=%b", k, o_sym_start, (k % 5 == 4));
            end
        end
    endtask

    task automatic test_frame();
        logic [4:0] exp_s [8] = '{5'b11111, 5'b11000, 5'b10001, 5'b01011,
                                  5'b10110, 5'b01101, 5'b00111, 5'b11111};
        logic       en_v  [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        logic [3:0] nib_v [8] = '{4'h0, 4'h0, 4'h5, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0};
        logic       exp_a [8] = '{0, 0, 1, 1, 0, 0, 0, 0};
        logic ack;
        logic [4:0] got;
        int acks = 0;
        for (int b = 0; b < 8; b++) begin
            drive_bnd(en_v[b], 1'b0, nib_v[b], b == 0, ack);
            if (ack === 1'b1) acks++;
            total++;
            if (ack !== exp_a[b]) begin bad++; $display("FAIL frame_ack[%0d]: got=%b want=%b", b, ack, exp_a[b]); end
        end
        i_tx_en = 1'b0;
        repeat (2) @(negedge i_clk);
        for (int i = 0; i < 8; i++) begin
            got = (i < sym_q.size()) ? sym_q[i] : 5'bx;
            total++;
            if (got !== exp_s[i]) begin bad++; $display("FAIL frame_sym[%0d]: got=%b want=%b", i, got, exp_s[i]); end
        end
        total++;
        if (acks != 2) begin bad++; $display("FAIL frame_ack_count: got=%0d want=2", acks); end
    endtask

    task automatic test_tx_er();
        logic [4:0] exp_s [6] = '{5'b11111, 5'b11000, 5'b10001, 5'b00100, 5'b01101, 5'b00111};
        logic       en_v  [6] = '{1, 1, 1, 0, 0, 0};
        logic       er_v  [6] = '{0, 0, 1, 0, 0, 0};
        logic       exp_a [6] = '{0, 0, 1, 0, 0, 0};
        logic ack;
        logic [4:0] got;
        for (int b = 0; b < 6; b++) begin
            drive_bnd(en_v[b], er_v[b], 4'h3, b == 0, ack);
            total++;
            if (ack !== exp_a[b]) begin bad++; $display("FAIL err_ack[%0d]: got=%b want=%b", b, ack, exp_a[b]); end
        end
        i_tx_en = 1'b0;
        i_tx_er = 1'b0;
        repeat (2) @(negedge i_clk);
        for (int i = 0; i < 6; i++) begin
            got = (i < sym_q.size()) ? sym_q[i] : 5'bx;
            total++;
            if (got !== exp_s[i]) begin bad++; $display("FAIL err_sym[%0d]: got=%b want=%b", i, got, exp_s[i]); end
        end
    endtask

    task automatic test_j_only();
        logic [4:0] exp_s [6] = '{5'b11111, 5'b11000, 5'b10001, 5'b01101, 5'b00111, 5'b11111};
        logic ack;
        logic [4:0] got;
        int acks = 0;
        for (int b = 0; b < 6; b++) begin
            drive_bnd(b == 0, 1'b0, 4'h9, b == 0, ack);
            if (ack === 1'b1) acks++;
        end
        i_tx_en = 1'b0;
        repeat (2) @(negedge i_clk);
        for (int i = 0; i < 6; i++) begin
            got = (i < sym_q.size()) ? sym_q[i] : 5'bx;
            total++;
            if (got !== exp_s[i]) begin bad++; $display("FAIL jonly_sym[%0d]: got=%b want=%b", i, got, exp_s[i]); end
        end
        total++;
        if (acks != 0) begin bad++; $display("FAIL jonly_ack_count: got=%0d want=0", acks); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_s [10] = '{5'b11111, 5'b11000, 5'b10001, 5'b01101, 5'b00111,
                                   5'b11111, 5'b11000, 5'b10001, 5'b01101, 5'b00111};
        logic       en_v  [10] = '{1, 1, 0, 1, 1, 1, 0, 0, 0, 0};
        logic ack;
        logic [4:0] got;
        for (int b = 0; b < 10; b++) drive_bnd(en_v[b], 1'b0, 4'h2, b == 0, ack);
        i_tx_en = 1'b0;
        repeat (2) @(negedge i_clk);
        for (int i = 0; i < 10; i++) begin
            got = (i < sym_q.size()) ? sym_q[i] : 5'bx;
            total++;
            if (got !== exp_s[i]) begin bad++; $display("FAIL b2b_sym[%0d]: got=%b want=%b", i, got, exp_s[i]); end
        end
    endtask

    task automatic test_reset_mid_data();
        logic ack;
        logic [4:0] got;
        for (int b = 0; b < 4; b++) drive_bnd(1'b1, 1'b0, 4'h7, 1'b0, ack);
        i_tx_en = 1'b0;
        i_tx_er = 1'b0;
        @(posedge i_clk);
        @(posedge i_clk);
        #3 i_res_n = 1'b0;
        #1;
        total++; if (o_txdata !== 1'b0)    begin bad++; $display("FAIL mid_rst_txdata: got=%b want=0", o_txdata); end
        total++; if (o_sym_start !== 1'b0) begin bad++; $display("FAIL mid_rst_sym_start: got=%b want=0", o_sym_start); end
        repeat (2) @(negedge i_clk);
        #1 i_res_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge i_clk);
            total++;
            if (o_txdata !== 1'(k % 2)) begin
                bad++; $display("FAIL mid_idle_toggle[%0d]: got=%b want=%b", k, o_txdata, 1'(k % 2));
            end
            total++;
            if (o_sym_start !== (k % 5 == 4)) begin
                bad++; $display("FAIL mid_idle_sym_start[%0d]: got=%b want=%b", k, o_sym_start, (k % 5 == 4));
            end
        end
        for (int b = 0; b < 4; b++) drive_bnd(1'b0, 1'b0, 4'h0, b == 0, ack);
        i_tx_en = 1'b0;
        repeat (2) @(negedge i_clk);
        for (int i = 0; i < 4; i++) begin
            got = (i < sym_q.size()) ? sym_q[i] : 5'bx;
            total++;
            if (got !== 5'b11111) begin bad++; $display("FAIL mid_post_sym[%0d]: got=%b want=11111", i, got); end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_tx_er();
        test_j_only();
        test_back_to_back();
        test_reset_mid_data();
        total++;
        if (stray_ack != 0) begin bad++; $display("FAIL stray_nib_ack: got=%0d want=0", stray_ack); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
